fetch_unit: RTL and testbench

- Instruction fetch sequencer; the producer side of the control unit's instruction-field interface and the consumer of its PCsrc output.
- Holds the PC and issues word reads to a synchronous instruction memory with 1-cycle latency.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake, splitting each word into Cond/OP/Funct fields.
- On a taken branch (PCsrc), flushes buffered and in-flight words and redirects to the branch target.

---
 rtl/fetch_pkg.sv | 49 ++++
 rtl/fetch_buffer.sv | 71 +++++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
// Holds the instruction field positions, opcode classes, the fetch FSM state
// type and the layout of one instruction buffer entry.
package fetch_pkg;

    localparam int WORD_W     = 32;
    localparam int MAX_ADDR_W = 32;

    // Instruction field bit positions
    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;

    // Opcode classes carried in the OP field
    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10
    } op_class_t;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;

    // One buffered instruction: its fetch address and the returned word
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [WORD_W-1:0]     word;
    } fetch_entry_t;

    function automatic logic [3:0] get_cond(input logic [WORD_W-1:0] w);
        return w[COND_MSB:COND_LSB];
    endfunction

    function automatic logic [1:0] get_op(input logic [WORD_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] get_funct(input logic [WORD_W-1:0] w);
        return w[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO holding fetched instructions.
// Head is read combinationally from the storage array so a word pushed at an
// edge is visible right after it. Flush clears pointers and count in one cycle
// and takes priority over a push in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t            mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    full;
    logic                    do_push;
    logic                    do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

    // The fetch credit rule must never let a push land on a full buffer
    assert property (@(posedge clk) disable iff (!rst) !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Holds the PC, issues word reads to a 1-cycle-latency instruction memory,
// buffers returned words and hands them to decode over valid/ready with the
// Cond/OP/Funct fields split out. A taken branch (pcsrc) flushes buffered and
// in-flight words (via an epoch tag) and redirects fetch to the target.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating perf_fetched and
// perf_flushes counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] branch_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushes
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] req_pc_reg;
    logic              outstanding_reg;
    logic              epoch_reg;
    logic              tag_reg;

    logic [CNT_W-1:0]  buf_count;
    logic              buf_empty;
    fetch_entry_t      buf_head;
    fetch_entry_t      push_entry;
    logic              push;
    logic              pop;
    logic              issue;
    logic              credit_ok;
    logic [CRD_W-1:0]  in_use;
    logic [ADDR_W-1:0] target_aligned;
    logic              unused_target_lsbs;

    // Low target bits are discarded: fetch is always word aligned
    assign target_aligned     = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    assign instr_valid = ~buf_empty;
    assign pop         = instr_valid & instr_ready;

    // Slots committed after this cycle: buffered + in flight - leaving now
    assign in_use    = CRD_W'(buf_count) + CRD_W'(outstanding_reg) - CRD_W'(pop);
    assign credit_ok = (in_use < CRD_W'(BUF_DEPTH));

    // Request decision; a redirect in this cycle always suppresses the request
    always_comb begin
        issue = 1'b0;
        if (!pcsrc) begin
            case (state_reg)
                RUN:     issue = credit_ok;
                REDIR:   issue = 1'b1;
                default: issue = 1'b0;
            endcase
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_reg;

    // Only a response to our single outstanding request from the current epoch is kept
    assign push          = imem_rvalid & outstanding_reg & (tag_reg == epoch_reg);
    assign push_entry.pc   = MAX_ADDR_W'(req_pc_reg);
    assign push_entry.word = imem_rdata;

    // Sequencer FSM, PC, epoch and in-flight request tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            req_pc_reg      <= '0;
            outstanding_reg <= 1'b0;
            epoch_reg       <= 1'b0;
            tag_reg         <= 1'b0;
        end else begin
            outstanding_reg <= issue;
            if (issue) begin
                tag_reg    <= epoch_reg;
                req_pc_reg <= pc_reg;
                pc_reg     <= pc_reg + ADDR_W'(4);
            end
            if (pcsrc) begin
                pc_reg    <= target_aligned;
                epoch_reg <= ~epoch_reg;
                state_reg <= REDIR;
            end else begin
                case (state_reg)
                    BOOT:    state_reg <= RUN;
                    REDIR:   state_reg <= RUN;
                    RUN:     state_reg <= RUN;
                    default: state_reg <= BOOT;
                endcase
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (pcsrc),
        .count     (buf_count),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    // Head outputs read as zero whenever nothing is presented
    assign instr    = instr_valid ? buf_head.word : '0;
    assign instr_pc = instr_valid ? buf_head.pc[ADDR_W-1:0] : '0;
    assign cond     = get_cond(instr);
    assign op       = get_op(instr);
    assign funct    = get_funct(instr);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_flushes_reg;

    // Saturating counts of delivered instructions and redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_reg <= '0;
            perf_flushes_reg <= '0;
        end else begin
            if (pop && (perf_fetched_reg != '1)) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (pcsrc && (perf_flushes_reg != '1)) begin
                perf_flushes_reg <= perf_flushes_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_flushes = perf_flushes_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for the fetch sequencer.
// A memory model answers every request one cycle later with addr-as-data.
// Expected instructions are queued when the memory response is driven and
// compared against the head every cycle it is presented.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          ADDR_W    = 32;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [31:0] instr_pc;
    logic        pcsrc = 1'b0;
    logic [31:0] branch_target = '0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .instr_pc      (instr_pc),
        .pcsrc         (pcsrc),
        .branch_target (branch_target)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_req    = 0;
    int           n_pop    = 0;
    fetch_state_t m_state  = BOOT;
    logic [31:0]  m_pc     = RESET_PC;
    logic [31:0]  m_prev_pc = '0;
    logic         m_out    = 1'b0;
    logic         mem_pend = 1'b0;
    logic [31:0]  mem_addr = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, check #1 later, advance the model
    task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt);
        exp_t e;
        logic pop_e;
        logic exp_req;
        int   used;
        instr_ready   = rdy;
        pcsrc         = br;
        branch_target = tgt;
        imem_rvalid   = mem_pend;
        imem_rdata    = mem_addr;
        #1;
        check_val("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb[0];
            check_val("instr_pc", instr_pc, e.pc);
            check_val("instr", instr, e.word);
            check_val("cond", 32'(cond), 32'(e.word[31:28]));
            check_val("op", 32'(op), 32'(e.word[27:26]));
            check_val("funct", 32'(funct), 32'(e.word[25:20]));
        end
        pop_e   = (sb.size() != 0) && rdy;
        used    = sb.size() + int'(m_out) - int'(pop_e);
        exp_req = !br && ((m_state == REDIR) || ((m_state == RUN) && (used < BUF_DEPTH)));
        check_val("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req && exp_req) begin
            check_val("imem_addr", imem_addr, m_pc);
        end
        mem_pend = imem_req;
        mem_addr = imem_addr;
        if (imem_req) n_req++;
        if (pop_e) begin
            void'(sb.pop_front());
            n_pop++;
        end
        if (br) begin
            sb.delete();
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_state = REDIR;
            m_out   = 1'b0;
        end else begin
            if (imem_rvalid && m_out) begin
                sb.push_back('{pc: m_prev_pc, word: m_prev_pc});
            end
            m_out = exp_req;
            if (exp_req) begin
                m_prev_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_state = RUN;
        end
        @(negedge clk);
    endtask

    // Assert reset between edges, check outputs clear at once, release on a negedge
    task automatic do_reset(input int hold);
        #2 rst = 1'b0;
        #1;
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_val("rst_instr", instr, 32'd0);
        check_val("rst_instr_pc", instr_pc, 32'd0);
        sb.delete();
        m_pc    = RESET_PC;
        m_state = BOOT;
        m_out   = 1'b0;
        repeat (hold) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int base;
        @(negedge clk);
        do_reset(2);

        // Stall from reset: only BUF_DEPTH requests, head 0x0 held steady
        base = n_req;
        repeat (7) cycle(1'b0, 1'b0, '0);
        check_val("stall_req_count", 32'(n_req - base), 32'(BUF_DEPTH));

        // Release and stream
        repeat (8) cycle(1'b1, 1'b0, '0);

        // Fill the buffer, then redirect to 0x100 while it holds two words
        repeat (4) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0100);
        repeat (6) cycle(1'b1, 1'b0, '0);

        // Redirect coinciding with a pop, misaligned target
        cycle(1'b1, 1'b1, 32'h0000_0103);
        repeat (5) cycle(1'b1, 1'b0, '0);

        // PC wrap at the top of the address space, plus full throughput
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (2) cycle(1'b1, 1'b0, '0);
        base = n_pop;
        repeat (6) cycle(1'b1, 1'b0, '0);
        check_val("throughput_pops", 32'(n_pop - base), 32'd6);

        // Random ready and occasional redirects
        for (int i = 0; i < 250; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);
        end

        // Asynchronous reset in the middle of a burst
        repeat (4) cycle(1'b1, 1'b0, '0);
        do_reset(1);
        repeat (8) cycle(1'b1, 1'b0, '0);

        // Redirect during BOOT then again during REDIR: latest target wins
        do_reset(1);
        cycle(1'b1, 1'b1, 32'h0000_0200);
        cycle(1'b1, 1'b1, 32'h0000_0300);
        repeat (8) cycle(1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
